flag_register_unit: RTL

- Architectural condition-code register (Z, N, V) feeding the PC update / branch-resolution stage.
- Captures flags from the ALU result at writeback; only flag-writing opcodes modify them, per opcode mask.
- Tracks flag-writing instructions in flight between issue and writeback.
- Raises flags_busy so decode holds a conditional branch until its flags are architecturally valid.

---
 rtl/flag_register_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/flag_register_unit.sv
// flag_register_unit
// Architectural Z/N/V condition-code register with an in-flight tracker for
// flag-writing instructions. Flags are captured from the ALU result at
// writeback according to the opcode class. flags_busy lets decode hold a
// conditional branch until the flags it depends on have retired. err is a
// sticky protocol-violation indicator: a tracked writer missing its
// writeback, or a writeback that was never tracked.

module flag_register_unit #(
    parameter int WIDTH        = 16,
    parameter int PIPE_DEPTH   = 2,
    parameter int FLUSH_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [3:0]       issue_op,
    input  logic             stall,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [3:0]       wb_op,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             wb_ovfl,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             flags_busy,
    output logic             err
);

    localparam int LAST = PIPE_DEPTH - 1;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'b00,
        CLS_ZONLY = 2'b01,
        CLS_FULL  = 2'b10
    } op_class_e;

    // Opcode classification: which flags an opcode is allowed to write.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            4'b0000: cls = CLS_FULL;   // ADD
            4'b0001: cls = CLS_FULL;   // SUB
            4'b0010: cls = CLS_ZONLY;  // XOR
            4'b0100: cls = CLS_ZONLY;  // SLL
            4'b0101: cls = CLS_ZONLY;  // SRA
            4'b0110: cls = CLS_ZONLY;  // ROR
            default: cls = CLS_NONE;   // RED, PADDSB and everything else
        endcase
        return cls;
    endfunction

    logic [PIPE_DEPTH-1:0] pend_q, pend_d;
    logic                  z_q, z_d;
    logic                  n_q, n_d;
    logic                  v_q, v_d;
    logic                  err_q, err_d;

    op_class_e issue_cls_s;
    op_class_e wb_cls_s;
    logic      issue_writer_s;
    logic      wb_writer_s;
    logic      result_zero_s;

    assign issue_cls_s    = op_class(issue_op);
    assign wb_cls_s       = op_class(wb_op);
    assign issue_writer_s = (issue_cls_s != CLS_NONE);
    assign wb_writer_s    = wb_valid & (wb_cls_s != CLS_NONE);
    assign result_zero_s  = (wb_result == {WIDTH{1'b0}});

    // In-flight tracker next state: shift unless stalled, then flush clears the youngest stages.
    always_comb begin
        pend_d = pend_q;
        if (!stall) begin
            // A flushed issue is discarded even when no stage is cleared.
            pend_d[0] = issue_valid & issue_writer_s & ~flush;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pend_d[i] = pend_q[i-1];
            end
        end else begin
            pend_d = pend_q;
        end
        if (flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (i < FLUSH_STAGES) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = pend_d[i];
                end
            end
        end else begin
            pend_d = pend_d;
        end
    end

    // Flag next state: writeback is never blocked by stall or flush.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        v_d = v_q;
        if (wb_valid) begin
            case (wb_cls_s)
                CLS_FULL: begin
                    z_d = result_zero_s;
                    n_d = wb_result[WIDTH-1];
                    v_d = wb_ovfl;
                end
                CLS_ZONLY: begin
                    z_d = result_zero_s;
                end
                default: begin
                    z_d = z_q;
                end
            endcase
        end else begin
            z_d = z_q;
        end
    end

    // Sticky protocol error: tracked writer without writeback, or untracked writeback.
    always_comb begin
        err_d = err_q;
        if (pend_q[LAST] != wb_writer_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset drops all in-flight tracking immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= {PIPE_DEPTH{1'b0}};
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            z_q    <= z_d;
            n_q    <= n_d;
            v_q    <= v_d;
            err_q  <= err_d;
        end
    end

    assign Z          = z_q;
    assign N          = n_q;
    assign V          = v_q;
    assign flags_busy = |pend_q;
    assign err        = err_q;

endmodule
